// File: rtl/bpm_pkg.sv
// Shared definitions for the multi-channel heart-rate monitor.
// Contents:
//   state_t  - output stream FSM states (IDLE, SEND)
//   is_pow2  - power-of-two test used to validate AVG_DEPTH at elaboration
//   sat_mul  - beat count times scale, clamped to the BPM result width
package bpm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // The product is formed at 64 bits so even a saturated 16-bit count
    // times a large scale cannot wrap before the clamp is applied.
    function automatic logic [31:0] sat_mul(input logic [15:0] cnt,
                                            input int scale,
                                            input int w);
        logic [63:0] prod;
        logic [63:0] maxv;
        prod = 64'(cnt) * 64'(scale);
        maxv = (64'd1 << w) - 64'd1;
        return (prod > maxv) ? 32'(maxv) : 32'(prod);
    endfunction

endpackage

// File: rtl/bpm_channel.sv
// One pulse channel of the heart-rate monitor.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   pulse_i      - raw beat pulse; a beat is a 0->1 transition
//   terminal_i   - last cycle of the shared window
//   compute_i    - cycle after terminal; bpm/history/avg update here
//   load_i       - compute cycle entered while the stream is idle;
//                  refreshes the copies that feed the output stream
//   bpm_o/avg_o/alarm_o - registered results for the output mux
module bpm_channel
    import bpm_pkg::*;
#(
    parameter int SCALE_FACTOR = 12,
    parameter int BPM_W        = 8,
    parameter int AVG_DEPTH    = 4,
    parameter int LOW_BPM      = 40,
    parameter int HIGH_BPM     = 180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_i,
    input  logic             terminal_i,
    input  logic             compute_i,
    input  logic             load_i,
    output logic [BPM_W-1:0] bpm_o,
    output logic [BPM_W-1:0] avg_o,
    output logic [1:0]       alarm_o
);

    localparam int SHIFT = $clog2(AVG_DEPTH);
    localparam int SUM_W = BPM_W + SHIFT + 1;
    localparam logic [BPM_W-1:0] LOW_T  = BPM_W'(LOW_BPM);
    localparam logic [BPM_W-1:0] HIGH_T = BPM_W'(HIGH_BPM);

    logic             prev_q;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;
    logic [15:0]      snap_q;
    logic [BPM_W-1:0] hist_q [AVG_DEPTH];
    logic [BPM_W-1:0] bpm_q;
    logic [BPM_W-1:0] avg_q;
    logic [1:0]       alarm_q;

    logic             beat;
    logic [BPM_W-1:0] bpmNow;
    logic [SUM_W-1:0] sum;
    logic [BPM_W-1:0] avgNow;
    logic [1:0]       alarmNow;

    // cnt_d already includes a beat seen this cycle, so an edge in the
    // terminal cycle lands in the snapshot of the closing window.
    // The average sums the incoming bpm with the AVG_DEPTH-1 newest
    // history entries, i.e. the history as it will look after the push.
    always_comb begin
        beat     = pulse_i & ~prev_q;
        cnt_d    = (beat && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
        bpmNow   = BPM_W'(sat_mul(snap_q, SCALE_FACTOR, BPM_W));
        sum      = SUM_W'(bpmNow);
        for (int i = 0; i < AVG_DEPTH - 1; i++) begin
            sum = sum + SUM_W'(hist_q[i]);
        end
        avgNow   = BPM_W'(sum >> SHIFT);
        alarmNow = {bpmNow > HIGH_T, bpmNow < LOW_T};
    end

    // History keeps updating on every compute cycle, while the output
    // copies only refresh when the stream is free to carry them.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            snap_q  <= '0;
            bpm_q   <= '0;
            avg_q   <= '0;
            alarm_q <= '0;
            for (int i = 0; i < AVG_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            prev_q <= pulse_i;
            if (terminal_i) begin
                snap_q <= cnt_d;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_d;
            end
            if (compute_i) begin
                hist_q[0] <= bpmNow;
                for (int i = 1; i < AVG_DEPTH; i++) begin
                    hist_q[i] <= hist_q[i-1];
                end
                if (load_i) begin
                    bpm_q   <= bpmNow;
                    avg_q   <= avgNow;
                    alarm_q <= alarmNow;
                end
            end
        end
    end

    assign bpm_o   = bpm_q;
    assign avg_o   = avg_q;
    assign alarm_o = alarm_q;

endmodule

// File: rtl/multi_bpm_monitor.sv
// Multi-channel heart-rate meter top level.
// Counts beats per channel over a shared window, converts them to BPM,
// keeps a moving average, and streams per-channel results.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   pulse_in    - NUM_CH beat pulse inputs
//   out_valid / out_ready - result stream handshake
//   out_ch, out_bpm, out_avg, out_alarm - current result beat
//   overrun     - sticky flag: a window's results were dropped
module multi_bpm_monitor
    import bpm_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int WINDOW_CYCLES = 1000,
    parameter int SCALE_FACTOR  = 12,
    parameter int BPM_W         = 8,
    parameter int AVG_DEPTH     = 4,
    parameter int LOW_BPM       = 40,
    parameter int HIGH_BPM      = 180,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] pulse_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [BPM_W-1:0]  out_bpm,
    output logic [BPM_W-1:0]  out_avg,
    output logic [1:0]        out_alarm,
    output logic              overrun
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    if (!is_pow2(AVG_DEPTH) || AVG_DEPTH > 16) begin : g_bad_depth
        $error("AVG_DEPTH must be a power of two in 1..16");
    end

    logic [WIN_W-1:0] winCnt_q;
    logic [WIN_W-1:0] winCnt_d;
    logic             terminal;
    logic             compute_q;
    logic             load;
    state_t           state_q;
    state_t           state_d;
    logic [CH_W-1:0]  ptr_q;
    logic [CH_W-1:0]  ptr_d;
    logic             overrun_q;

    logic [BPM_W-1:0] chBpm   [NUM_CH];
    logic [BPM_W-1:0] chAvg   [NUM_CH];
    logic [1:0]       chAlarm [NUM_CH];

    // Window counter wraps straight from the last cycle to 0, so every
    // cycle belongs to exactly one window.
    always_comb begin
        terminal = (winCnt_q == WIN_LAST);
        winCnt_d = terminal ? '0 : winCnt_q + WIN_W'(1);
        load     = compute_q && (state_q == IDLE);
    end

    // A compute cycle that finds the stream busy drops its results; the
    // undrained stream keeps its old values and finishes normally.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (compute_q) begin
                    state_d = SEND;
                    ptr_d   = '0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (ptr_q == LAST_CH) begin
                        state_d = IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d   = ptr_q + CH_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            winCnt_q  <= '0;
            compute_q <= 1'b0;
            state_q   <= IDLE;
            ptr_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            winCnt_q  <= winCnt_d;
            compute_q <= terminal;
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            if (compute_q && (state_q == SEND)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        bpm_channel #(
            .SCALE_FACTOR (SCALE_FACTOR),
            .BPM_W        (BPM_W),
            .AVG_DEPTH    (AVG_DEPTH),
            .LOW_BPM      (LOW_BPM),
            .HIGH_BPM     (HIGH_BPM)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .pulse_i    (pulse_in[g]),
            .terminal_i (terminal),
            .compute_i  (compute_q),
            .load_i     (load),
            .bpm_o      (chBpm[g]),
            .avg_o      (chAvg[g]),
            .alarm_o    (chAlarm[g])
        );
    end

    // Data outputs read as zero whenever no beat is being offered.
    assign out_valid = (state_q == SEND);
    assign out_ch    = ptr_q;
    assign out_bpm   = out_valid ? chBpm[ptr_q]   : '0;
    assign out_avg   = out_valid ? chAvg[ptr_q]   : '0;
    assign out_alarm = out_valid ? chAlarm[ptr_q] : '0;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_multi_bpm_monitor.sv
// Scoreboard bench for multi_bpm_monitor with a 100-cycle window.
// The stimulus process pushes the hand-computed results of each window
// when its terminal cycle is driven; a monitor pops them on transfers.
module tb_multi_bpm_monitor;

    localparam int W = 100;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] bpm;
        logic [7:0] avg;
        logic [1:0] alarm;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pulse_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_ch;
    logic [7:0] out_bpm;
    logic [7:0] out_avg;
    logic [1:0] out_alarm;
    logic       overrun;

    beat_t expQ[$];
    int    nChecks = 0;
    int    nPass   = 0;
    int    relCyc  = 0;

    multi_bpm_monitor #(
        .NUM_CH        (4),
        .WINDOW_CYCLES (W),
        .SCALE_FACTOR  (12),
        .BPM_W         (8),
        .AVG_DEPTH     (4),
        .LOW_BPM       (40),
        .HIGH_BPM      (180)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pulse_in  (pulse_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_bpm   (out_bpm),
        .out_avg   (out_avg),
        .out_alarm (out_alarm),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Cycle index within the current run; 0 is the first cycle after reset.
    always @(posedge clk) begin
        if (reset) relCyc <= 0;
        else       relCyc <= relCyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic pushBeat(input int ch, input int bpm, input int avg, input int alarm);
        beat_t b;
        b.ch    = 2'(ch);
        b.bpm   = 8'(bpm);
        b.avg   = 8'(avg);
        b.alarm = 2'(alarm);
        expQ.push_back(b);
    endtask

    // Expected results per phase and window (alarm: 1 = low, 2 = high).
    task automatic pushWindow(input int phase, input int w);
        case (phase)
            1: begin
                case (w)
                    0: begin pushBeat(0, 60, 15, 0); pushBeat(1, 0, 0, 1);
                             pushBeat(2, 255, 63, 2); pushBeat(3, 0, 0, 1); end
                    1: begin pushBeat(0, 12, 18, 1); pushBeat(1, 0, 0, 1);
                             pushBeat(2, 255, 127, 2); pushBeat(3, 180, 45, 0); end
                    2: begin pushBeat(0, 12, 21, 1); pushBeat(1, 0, 0, 1);
                             pushBeat(2, 255, 191, 2); pushBeat(3, 0, 45, 1); end
                    3: begin pushBeat(0, 12, 24, 1); pushBeat(1, 0, 0, 1);
                             pushBeat(2, 255, 255, 2); pushBeat(3, 0, 45, 1); end
                    default: ;
                endcase
            end
            2: begin
                if (w == 0) begin
                    pushBeat(0, 36, 9, 1); pushBeat(1, 0, 0, 1);
                    pushBeat(2, 0, 0, 1);  pushBeat(3, 0, 0, 1);
                end else if (w == 3) begin
                    pushBeat(0, 12, 39, 1); pushBeat(1, 0, 0, 1);
                    pushBeat(2, 0, 0, 1);   pushBeat(3, 0, 0, 1);
                end
            end
            3: if (w == 0) begin
                pushBeat(0, 72, 18, 0); pushBeat(1, 0, 0, 1);
                pushBeat(2, 0, 0, 1);   pushBeat(3, 0, 0, 1);
            end
            4: if (w == 0) begin
                pushBeat(0, 0, 0, 1);  pushBeat(1, 60, 15, 0);
                pushBeat(2, 0, 0, 1);  pushBeat(3, 0, 0, 1);
            end
            default: ;
        endcase
    endtask

    function automatic logic [3:0] pulsePat(input int phase, input int w, input int pos);
        logic [3:0] p;
        bit odd;
        int n;
        p   = '0;
        odd = (pos % 2) == 1;
        case (phase)
            1: begin
                case (w)
                    0: p[0] = (pos % 10 == 0) && pos >= 10 && pos <= 50;
                    1: p[0] = (pos == W - 1);
                    2: p[0] = (pos >= 10) && (pos < 60);
                    3: p[0] = (pos == 0);
                    default: p[0] = 1'b0;
                endcase
                p[2] = (w <= 3) && odd && pos < 50;
                p[3] = (w == 1) && odd && pos < 30;
            end
            2: begin
                case (w)
                    0: n = 3;
                    1: n = 7;
                    2: n = 2;
                    3: n = 1;
                    default: n = 4;
                endcase
                p[0] = odd && pos < 2 * n;
            end
            3: p[0] = (w == 0) && odd && pos < 12;
            4: p[1] = (w == 0) && odd && pos < 10;
            default: p = '0;
        endcase
        return p;
    endfunction

    task automatic applyStimulus(input int phase, input int nCycles);
        int w;
        int pos;
        for (int k = 0; k < nCycles; k++) begin
            w   = relCyc / W;
            pos = relCyc % W;
            pulse_in  = pulsePat(phase, w, pos);
            out_ready = (phase == 2) ? !(relCyc >= 100 && relCyc < 301) : 1'b1;
            if (phase == 2 && relCyc == 150) checkOutput("overrun_before_drop", 32'(overrun), 0);
            if (phase == 2 && relCyc == 250) checkOutput("overrun_after_drop", 32'(overrun), 1);
            if (phase == 2 && relCyc == 300)
                checkOutput("stall_hold_valid_ch", {30'd0, out_valid, out_ch == 2'd0}, 32'd3);
            if (phase >= 3 && relCyc == W)     checkOutput("valid_low_at_T1", 32'(out_valid), 0);
            if (phase >= 3 && relCyc == W + 1) checkOutput("valid_high_at_T2", 32'(out_valid), 1);
            if (pos == W - 1) pushWindow(phase, w);
            @(posedge clk);
            #1;
        end
        pulse_in  = '0;
        out_ready = 1'b1;
    endtask

    task automatic resetPulse(input string name);
        reset    = 1'b1;
        pulse_in = '0;
        expQ.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput(name, {19'd0, out_valid, out_ch, out_bpm, out_avg, out_alarm, overrun}, 0);
    endtask

    task automatic drainWait(input int maxCyc);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < maxCyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_queue_empty", 32'(expQ.size()), 0);
    endtask

    // Monitor: scoreboard pops on transfers, stall stability, and the
    // first-valid latency (T+2, i.e. window position 1).
    logic  prevValid = 1'b0;
    logic  stalled   = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        beat_t act;
        beat_t exp;
        if (reset) begin
            prevValid = 1'b0;
            stalled   = 1'b0;
        end else begin
            act = {out_ch, out_bpm, out_avg, out_alarm};
            if (out_valid && !prevValid)
                checkOutput("first_valid_latency", 32'(relCyc % W), 1);
            if (stalled)
                checkOutput("stall_stable", {11'd0, out_valid, act}, {11'd0, 1'b1, held});
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(act), 32'hFFFFFFFF);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput($sformatf("beat_ch%0d", exp.ch), 32'(act), 32'(exp));
                end
            end
            if (out_valid && !out_ready) held = act;
            stalled   = out_valid && !out_ready;
            prevValid = out_valid;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        resetPulse("reset_outputs_zero");

        // Phase 1: basic rates, saturation, window boundaries, held level.
        applyStimulus(1, 4 * W);
        drainWait(20);

        // Phase 2: consumer stall over two windows -> dropped results.
        resetPulse("reset_before_stall");
        applyStimulus(2, 4 * W + 50);
        checkOutput("overrun_sticky", 32'(overrun), 1);
        checkOutput("queue_empty_before_midreset", 32'(expQ.size()), 0);
        resetPulse("reset_mid_window");

        // Phase 3: first result after reset, then reset while streaming.
        applyStimulus(3, W + 2);
        checkOutput("in_send_before_reset", 32'(out_valid), 1);
        resetPulse("reset_in_send");

        // Phase 4: clean window after the streaming reset.
        applyStimulus(4, W + 2);
        drainWait(20);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
